fft_in_framer: RTL

//  Downstream of the PWL expander stage: takes 4 lanes x 8 signed 8-bit samples per beat.

---
 rtl/fft_framer_pkg.sv | 17 +
 rtl/fft_framer_bank.sv | 26 ++
 rtl/fft_in_framer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fft_framer_pkg.sv
// Shared defaults, write-FSM state encodings and sample packing helper for the FFT input framer.

package fft_framer_pkg;

    localparam int unsigned DEF_NLANE = 4;
    localparam int unsigned DEF_NSAMP = 8;
    localparam int unsigned DEF_DW    = 8;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;

    // Bit offset of lane l, sample k within a beat.
    function automatic int unsigned smp_idx(input int unsigned l, input int unsigned k);
        return (l * DEF_NSAMP + k) * DEF_DW;
    endfunction

endpackage

// File: rtl/fft_framer_bank.sv
// One frame buffer: FRAME_BEATS x BW registers, synchronous write, combinational read.

module fft_framer_bank #(
    parameter int unsigned FRAME_BEATS = 16,
    parameter int unsigned BW          = 256,
    parameter int unsigned AW          = $clog2(FRAME_BEATS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [BW-1:0] rdata
);

    logic [BW-1:0] mem [FRAME_BEATS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_in_framer.sv
// Collects fixed-length frames into ping-pong banks and streams whole frames to the FFT core.
// Optional FFT_FRAMER_STATS_EN adds saturating frame and drop counters.

module fft_in_framer
    import fft_framer_pkg::*;
#(
    parameter int unsigned NLANE       = DEF_NLANE,
    parameter int unsigned NSAMP       = DEF_NSAMP,
    parameter int unsigned DW          = DEF_DW,
    parameter int unsigned FRAME_BEATS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    input  logic                         in_sof,
    input  logic [NLANE*NSAMP*DW-1:0]    in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic                         out_sof,
    output logic                         out_eof,
    output logic [NLANE*NSAMP*DW-1:0]    out_data,
    output logic                         ovf,
    input  logic                         ovf_clr
`ifdef FFT_FRAMER_STATS_EN
    ,
    output logic [15:0]                  frm_cnt,
    output logic [15:0]                  drop_cnt
`endif
);

    localparam int unsigned BW   = NLANE * NSAMP * DW;
    localparam int unsigned CW   = $clog2(FRAME_BEATS);
    localparam logic [CW-1:0] LAST = CW'(FRAME_BEATS - 1);

    logic [0:0]    wr_state_q, wr_state_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          ovf_q, ovf_d;

    logic          we;
    logic [CW-1:0] waddr;
    logic          drop;
    logic          set_full;
    logic          clr_full;
    logic          out_hs;
    logic [BW-1:0] rdata0, rdata1, rdata;

    assign out_vld = full_q[rd_bank_q];
    assign out_hs  = out_vld & out_rdy;

    // Write side: a bank is only claimed by an sof that sees it free in the registered full flags.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        we         = 1'b0;
        waddr      = wr_cnt_q;
        drop       = 1'b0;
        set_full   = 1'b0;
        if (in_vld) begin
            case (wr_state_q)
                W_IDLE: begin
                    if (in_sof) begin
                        if (full_q[wr_bank_q]) begin
                            drop = 1'b1;
                        end else begin
                            we         = 1'b1;
                            waddr      = '0;
                            wr_cnt_d   = CW'(1);
                            wr_state_d = W_FILL;
                        end
                    end
                end
                W_FILL: begin
                    we = 1'b1;
                    if (in_sof) begin
                        waddr    = '0;
                        wr_cnt_d = CW'(1);
                    end else if (wr_cnt_q == LAST) begin
                        set_full   = 1'b1;
                        wr_bank_d  = ~wr_bank_q;
                        wr_cnt_d   = '0;
                        wr_state_d = W_IDLE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CW'(1);
                    end
                end
                default: wr_state_d = W_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        clr_full  = 1'b0;
        if (out_hs) begin
            if (rd_cnt_q == LAST) begin
                rd_cnt_d  = '0;
                rd_bank_d = ~rd_bank_q;
                clr_full  = 1'b1;
            end else begin
                rd_cnt_d = rd_cnt_q + CW'(1);
            end
        end
    end

    // Set and clear never target the same bank: set needs it empty, clear needs it full.
    always_comb begin
        full_d = full_q;
        if (set_full) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (clr_full) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    assign ovf_d = (ovf_q & ~ovf_clr) | drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    fft_framer_bank #(
        .FRAME_BEATS (FRAME_BEATS),
        .BW          (BW),
        .AW          (CW)
    ) u_bank0 (
        .clk   (clk),
        .we    (we & ~wr_bank_q),
        .waddr (waddr),
        .wdata (in_data),
        .raddr (rd_cnt_q),
        .rdata (rdata0)
    );

    fft_framer_bank #(
        .FRAME_BEATS (FRAME_BEATS),
        .BW          (BW),
        .AW          (CW)
    ) u_bank1 (
        .clk   (clk),
        .we    (we & wr_bank_q),
        .waddr (waddr),
        .wdata (in_data),
        .raddr (rd_cnt_q),
        .rdata (rdata1)
    );

    assign rdata    = rd_bank_q ? rdata1 : rdata0;
    assign out_data = out_vld ? rdata : '0;
    assign out_sof  = out_vld & (rd_cnt_q == '0);
    assign out_eof  = out_vld & (rd_cnt_q == LAST);
    assign ovf      = ovf_q;

`ifdef FFT_FRAMER_STATS_EN
    logic [15:0] frm_cnt_q, drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (clr_full && (frm_cnt_q != 16'hFFFF)) begin
                frm_cnt_q <= frm_cnt_q + 16'd1;
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign frm_cnt  = frm_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule
